// File: rtl/icg_enable_ctrl.sv
// icg_enable_ctrl: enable/test-enable controller for a negative-edge ICG with idle time-out, wake handshake and gated-cycle statistic
module icg_enable_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W = 5,
  parameter int STAT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BUSY,
  input  logic              FORCE_ON,
  input  logic              SCAN_MODE,
  input  logic              WAKE_REQ,
  input  logic              CLR_STAT,
  output logic              E,
  output logic              TE,
  output logic              WAKE_ACK,
  output logic              GATED,
  output logic [STAT_W-1:0] GATED_CNT
);
  localparam logic [1:0] S_RUN = 2'd0, S_IDLE = 2'd1, S_GATED = 2'd2, S_WAKE = 2'd3;
  localparam logic [CNT_W-1:0] IDLE_N = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_N = CNT_W'(WAKE_CYCLES);
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 2**CNT_W-1 || WAKE_CYCLES < 1 || WAKE_CYCLES > 2**CNT_W-1) begin : g_param_check
    $error("icg_enable_ctrl: IDLE_CYCLES/WAKE_CYCLES must be in 1..2^CNT_W-1");
  end
  logic [1:0] state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic armed, ack_n, hold;
  assign hold = BUSY | FORCE_ON;
  // A held request keeps the clock running; acks require the request to have been low since the last ack
  assign ack_n = armed & WAKE_REQ & (state == S_RUN || state == S_IDLE || (state == S_WAKE && cnt == WAKE_N));
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      S_RUN: if (!hold && !WAKE_REQ) begin
        state_n = S_IDLE;
        cnt_n = CNT_W'(1);
      end
      S_IDLE: if (hold || WAKE_REQ) begin
        state_n = S_RUN;
        cnt_n = '0;
      end else if (cnt == IDLE_N) begin
        state_n = S_GATED;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
      S_GATED: if (hold || WAKE_REQ) begin
        state_n = S_WAKE;
        cnt_n = CNT_W'(1);
      end
      default: if (cnt == WAKE_N) begin
        state_n = S_RUN;
        cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RUN;
      cnt <= '0;
      armed <= 1'b1;
      E <= 1'b1;
      TE <= 1'b0;
      WAKE_ACK <= 1'b0;
      GATED <= 1'b0;
      GATED_CNT <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      armed <= ack_n ? 1'b0 : (armed | ~WAKE_REQ);
      E <= state_n != S_GATED;
      TE <= SCAN_MODE;
      WAKE_ACK <= ack_n;
      GATED <= state_n == S_GATED;
      GATED_CNT <= CLR_STAT ? '0 : (GATED && !(&GATED_CNT)) ? GATED_CNT + 1'b1 : GATED_CNT;
    end
  end
endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb_icg_enable_ctrl: vector table, directed corner sequences and randomized run against a timing-based reference model
module tb_icg_enable_ctrl;
  logic clk = 0, rst = 1, busy = 0, fon = 0, scan = 0, req = 0, clr = 0;
  logic e1, te1, ack1, g1, e2, te2, ack2, g2;
  logic [15:0] cnt1;
  logic [3:0] cnt2;
  int tests = 0, fails = 0;

  icg_enable_ctrl dut1 (.CLK(clk), .RST(rst), .BUSY(busy), .FORCE_ON(fon), .SCAN_MODE(scan), .WAKE_REQ(req),
    .CLR_STAT(clr), .E(e1), .TE(te1), .WAKE_ACK(ack1), .GATED(g1), .GATED_CNT(cnt1));
  icg_enable_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(2), .CNT_W(5), .STAT_W(4)) dut2 (.CLK(clk), .RST(rst), .BUSY(busy),
    .FORCE_ON(fon), .SCAN_MODE(scan), .WAKE_REQ(req), .CLR_STAT(clr), .E(e2), .TE(te2), .WAKE_ACK(ack2), .GATED(g2),
    .GATED_CNT(cnt2));

  always #5 clk = ~clk;

  typedef struct {
    bit gated, armed, e, te, ack, g;
    int quiet, wake_rem, gcnt;
  } model_t;

  // Model counts consecutive quiet cycles and remaining wake cycles rather than tracking FSM states
  function automatic model_t step(model_t m, bit r, bit b, bit f, bit s, bit q, bit c, int idle, int wk, int smax);
    model_t n = m;
    if (r) begin
      n = '{default: 0};
      n.armed = 1;
      n.e = 1;
      return n;
    end
    n.te = s;
    n.ack = 0;
    n.gcnt = c ? 0 : (m.g && m.gcnt < smax) ? m.gcnt + 1 : m.gcnt;
    if (m.wake_rem > 0) begin
      if (m.wake_rem == 1) begin
        n.ack = q & m.armed;
        n.wake_rem = 0;
        n.quiet = 0;
      end else n.wake_rem = m.wake_rem - 1;
    end else if (m.gated) begin
      if (b | f | q) begin
        n.gated = 0;
        n.wake_rem = wk;
      end
    end else begin
      n.ack = q & m.armed;
      n.quiet = (b | f | q) ? 0 : m.quiet + 1;
      if (n.quiet == idle + 1) begin
        n.gated = 1;
        n.quiet = 0;
      end
    end
    n.armed = n.ack ? 0 : (!q | m.armed);
    n.e = !n.gated;
    n.g = n.gated;
    return n;
  endfunction

  model_t m1, m2;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m1 = step(m1, rst, busy, fon, scan, req, clr, 16, 2, 65535);
    m2 = step(m2, rst, busy, fon, scan, req, clr, 1, 2, 15);
    #1;
    chk("m1_e", e1, m1.e); chk("m1_te", te1, m1.te); chk("m1_ack", ack1, m1.ack);
    chk("m1_gated", g1, m1.g); chk("m1_cnt", cnt1, m1.gcnt);
    chk("m2_e", e2, m2.e); chk("m2_te", te2, m2.te); chk("m2_ack", ack2, m2.ack);
    chk("m2_gated", g2, m2.g); chk("m2_cnt", cnt2, m2.gcnt);
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    int n;
    bit rst, busy, fon, scan, req, clr;
    bit e, te, ack, g;
    int cnt;
  } vec_t;
  vec_t tbl [0:16];

  initial begin
    m1 = '{default: 0};
    m2 = '{default: 0};
    tbl = '{
      '{2,   1,0,0,0,0,0, 1,0,0,0,0},
      '{16,  0,0,0,0,0,0, 1,0,0,0,0},
      '{1,   0,0,0,0,0,0, 0,0,0,1,0},
      '{10,  0,0,0,0,0,0, 0,0,0,1,10},
      '{1,   0,0,0,0,1,0, 1,0,0,0,11},
      '{1,   0,0,0,0,1,0, 1,0,0,0,11},
      '{1,   0,0,0,0,1,0, 1,0,1,0,11},
      '{1,   0,0,0,0,1,0, 1,0,0,0,11},
      '{5,   0,0,0,0,1,0, 1,0,0,0,11},
      '{1,   0,0,0,0,0,0, 1,0,0,0,11},
      '{1,   0,0,0,0,1,0, 1,0,1,0,11},
      '{1,   0,0,0,1,0,0, 1,1,0,0,11},
      '{1,   0,0,1,0,0,0, 1,0,0,0,11},
      '{100, 0,0,1,0,0,0, 1,0,0,0,11},
      '{16,  0,0,0,0,0,0, 1,0,0,0,11},
      '{1,   0,1,0,0,0,0, 1,0,0,0,11},
      '{1,   0,1,0,0,0,0, 1,0,0,0,11}
    };
    #2;
    foreach (tbl[k]) begin
      {rst, busy, fon, scan, req, clr} = {tbl[k].rst, tbl[k].busy, tbl[k].fon, tbl[k].scan, tbl[k].req, tbl[k].clr};
      ticks(tbl[k].n);
      chk($sformatf("vec%0d_e", k), e1, tbl[k].e);
      chk($sformatf("vec%0d_te", k), te1, tbl[k].te);
      chk($sformatf("vec%0d_ack", k), ack1, tbl[k].ack);
      chk($sformatf("vec%0d_gated", k), g1, tbl[k].g);
      chk($sformatf("vec%0d_cnt", k), cnt1, tbl[k].cnt);
    end
    {busy, fon, scan, req, clr} = '0;
    rst = 1; tick(); rst = 0;
    ticks(17);
    chk("gated_before_rst", g1, 1);
    ticks(500);
    chk("cnt_500", cnt1, 500);
    rst = 1; tick();
    chk("rst_gated_e", e1, 1); chk("rst_gated_g", g1, 0); chk("rst_gated_ack", ack1, 0); chk("rst_gated_cnt", cnt1, 0);
    rst = 0; ticks(17);
    req = 1; tick();
    chk("wake_e", e1, 1); chk("wake_g", g1, 0);
    rst = 1; tick();
    chk("rst_wake_e", e1, 1); chk("rst_wake_ack", ack1, 0); chk("rst_wake_g", g1, 0); chk("rst_wake_cnt", cnt1, 0);
    rst = 0; req = 0; tick();
    rst = 1; tick(); rst = 0;
    tick();
    chk("idle1_first", g2, 0);
    tick();
    chk("idle1_gate", g2, 1);
    ticks(20);
    chk("sat_15", cnt2, 15);
    clr = 1; tick();
    chk("clr_0", cnt2, 0);
    clr = 0; tick();
    chk("after_clr_1", cnt2, 1);
    for (int i = 0; i < 3000; i++) begin
      int lvl;
      lvl = (i / 200) % 3;
      rst = $urandom_range(0, 299) == 0;
      busy = lvl == 0 ? 1'b0 : lvl == 1 ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 0);
      fon = $urandom_range(0, 99) == 0;
      scan = $urandom_range(0, 9) == 0 ? ~scan : scan;
      req = req ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
      clr = $urandom_range(0, 63) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
